// File: rtl/alu_pkg.sv
// Shared encodings for the execute-stage ALU: operation codes, aluop and funct values.
// Latency: n/a (definitions only); backpressure: n/a.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_NOR   = 2'b11;

  localparam logic [3:0] FUNCT_ADD = 4'b0000;
  localparam logic [3:0] FUNCT_SUB = 4'b0010;
  localparam logic [3:0] FUNCT_AND = 4'b0100;
  localparam logic [3:0] FUNCT_OR  = 4'b0101;
  localparam logic [3:0] FUNCT_XOR = 4'b0110;
  localparam logic [3:0] FUNCT_NOR = 4'b0111;
  localparam logic [3:0] FUNCT_SLT = 4'b1010;

endpackage

// File: rtl/add32.sv
// WIDTH-bit wrap-around adder with no carry out.
// Latency: combinational; backpressure: none.
module add32 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage: ALU control decode, combinational ALU, N/V/Z status register, PC+4 and branch-target adders.
// Latency: result/zero/adders combinational, flags one clk edge later; backpressure: none.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       aluop,
  input  logic [3:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] br_off,
  output logic [3:0]       alu_ctl,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             status_n,
  output logic             status_v,
  output logic             status_z,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] br_target
);

  localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

  logic overflow;
  logic slt_bit;

  always_comb begin
    alu_ctl = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alu_ctl = ALU_ADD;
      ALUOP_SUB: alu_ctl = ALU_SUB;
      ALUOP_NOR: alu_ctl = ALU_NOR;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD: alu_ctl = ALU_ADD;
          FUNCT_SUB: alu_ctl = ALU_SUB;
          FUNCT_AND: alu_ctl = ALU_AND;
          FUNCT_OR:  alu_ctl = ALU_OR;
          FUNCT_XOR: alu_ctl = ALU_XOR;
          FUNCT_NOR: alu_ctl = ALU_NOR;
          FUNCT_SLT: alu_ctl = ALU_SLT;
          default:   alu_ctl = ALU_ADD;
        endcase
      end
      default: alu_ctl = ALU_ADD;
    endcase
  end

  // Direct signed compare so SLT stays correct when a - b would overflow.
  assign slt_bit = ($signed(a) < $signed(b));

  always_comb begin
    result = '0;
    case (alu_ctl)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_XOR: result = a ^ b;
      ALU_SUB: result = a - b;
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, slt_bit};
      ALU_NOR: result = ~(a | b);
      default: result = '0;
    endcase
  end

  always_comb begin
    overflow = 1'b0;
    case (alu_ctl)
      ALU_ADD: overflow = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      ALU_SUB: overflow = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      default: overflow = 1'b0;
    endcase
  end

  assign zero = (result == '0);

  // Flags describe the previous cycle's instruction for the brv/baln/blezal logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_n <= 1'b0;
      status_v <= 1'b0;
      status_z <= 1'b0;
    end else begin
      status_n <= result[WIDTH-1];
      status_v <= overflow;
      status_z <= zero;
    end
  end

  add32 #(.WIDTH(WIDTH)) u_pc_plus4 (
    .a   (pc),
    .b   (PC_STEP),
    .sum (pc_plus4)
  );

  add32 #(.WIDTH(WIDTH)) u_br_target (
    .a   (pc_plus4),
    .b   (br_off),
    .sum (br_target)
  );

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: vector table for decode/ALU/adders, flag scoreboard, async reset sequence.
module tb_alu_exec_unit;

  logic        clk;
  logic        rst;
  logic [1:0]  aluop;
  logic [3:0]  funct;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] pc;
  logic [31:0] br_off;
  logic [3:0]  alu_ctl;
  logic [31:0] result;
  logic        zero;
  logic        status_n;
  logic        status_v;
  logic        status_z;
  logic [31:0] pc_plus4;
  logic [31:0] br_target;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [1:0]  aluop;
    logic [3:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  exp_ctl;
    logic [31:0] exp_res;
    logic        exp_n;
    logic        exp_v;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] br_off;
    logic [31:0] exp_pc4;
    logic [31:0] exp_bt;
  } add_vec_t;

  typedef struct {
    string      name;
    logic [2:0] nvz;
  } flag_exp_t;

  vec_t      vecs[15];
  add_vec_t  avecs[4];
  flag_exp_t flag_q[$];

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .aluop     (aluop),
    .funct     (funct),
    .a         (a),
    .b         (b),
    .pc        (pc),
    .br_off    (br_off),
    .alu_ctl   (alu_ctl),
    .result    (result),
    .zero      (zero),
    .status_n  (status_n),
    .status_v  (status_v),
    .status_z  (status_z),
    .pc_plus4  (pc_plus4),
    .br_target (br_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_flags(input string name, input logic [2:0] exp);
    check({name, " nvz"}, {29'd0, status_n, status_v, status_z}, {29'd0, exp});
  endtask

  task automatic pop_flags();
    flag_exp_t e;
    total++;
    if (flag_q.size() == 0) begin
      bad++;
      $display("FAIL flag_scoreboard: got empty queue expected an entry");
    end else begin
      total--;
      e = flag_q.pop_front();
      check_flags(e.name, e.nvz);
    end
  endtask

  task automatic set_vec(input int i, input string name, input logic [1:0] op, input logic [3:0] fn,
                         input logic [31:0] va, input logic [31:0] vb, input logic [3:0] ctl,
                         input logic [31:0] res, input logic n, input logic v);
    vecs[i].name    = name;
    vecs[i].aluop   = op;
    vecs[i].funct   = fn;
    vecs[i].a       = va;
    vecs[i].b       = vb;
    vecs[i].exp_ctl = ctl;
    vecs[i].exp_res = res;
    vecs[i].exp_n   = n;
    vecs[i].exp_v   = v;
  endtask

  // Drive at the falling edge, check combinational outputs, queue expected flags, check them after the rising edge.
  task automatic apply_vec(input vec_t v);
    flag_exp_t e;
    logic      exp_z;
    @(negedge clk);
    aluop = v.aluop;
    funct = v.funct;
    a     = v.a;
    b     = v.b;
    #1;
    exp_z = (v.exp_res == 32'd0);
    check({v.name, " alu_ctl"}, {28'd0, alu_ctl}, {28'd0, v.exp_ctl});
    check({v.name, " result"}, result, v.exp_res);
    check({v.name, " zero"}, {31'd0, zero}, {31'd0, exp_z});
    e.name = v.name;
    e.nvz  = {v.exp_n, v.exp_v, exp_z};
    flag_q.push_back(e);
    @(posedge clk);
    #1;
    pop_flags();
  endtask

  initial begin
    //      idx name        aluop  funct    a             b             ctl      result        N     V
    set_vec(0,  "add_ovf",  2'b00, 4'b0000, 32'h7FFFFFFF, 32'h00000001, 4'b0010, 32'h80000000, 1'b1, 1'b1);
    set_vec(1,  "sub_zero", 2'b01, 4'b0000, 32'h00000005, 32'h00000005, 4'b0110, 32'h00000000, 1'b0, 1'b0);
    set_vec(2,  "sub_ovf",  2'b01, 4'b0000, 32'h80000000, 32'h00000001, 4'b0110, 32'h7FFFFFFF, 1'b0, 1'b1);
    set_vec(3,  "r_and",    2'b10, 4'b0100, 32'hF0F0F0F0, 32'h0FF00FF0, 4'b0000, 32'h00F000F0, 1'b0, 1'b0);
    set_vec(4,  "r_or",     2'b10, 4'b0101, 32'hF0F0F0F0, 32'h0FF00FF0, 4'b0001, 32'hFFF0FFF0, 1'b1, 1'b0);
    set_vec(5,  "r_xor",    2'b10, 4'b0110, 32'hF0F0F0F0, 32'h0FF00FF0, 4'b0011, 32'hFF00FF00, 1'b1, 1'b0);
    set_vec(6,  "r_nor",    2'b10, 4'b0111, 32'hF0F0F0F0, 32'h0FF00FF0, 4'b1100, 32'h000F000F, 1'b0, 1'b0);
    set_vec(7,  "r_slt",    2'b10, 4'b1010, 32'hF0F0F0F0, 32'h0FF00FF0, 4'b0111, 32'h00000001, 1'b0, 1'b0);
    set_vec(8,  "slt_ovf",  2'b10, 4'b1010, 32'h7FFFFFFF, 32'h80000000, 4'b0111, 32'h00000000, 1'b0, 1'b0);
    set_vec(9,  "nori",     2'b11, 4'b0000, 32'h00000000, 32'h0000FFFF, 4'b1100, 32'hFFFF0000, 1'b1, 1'b0);
    set_vec(10, "r_add",    2'b10, 4'b0000, 32'h00000001, 32'h00000002, 4'b0010, 32'h00000003, 1'b0, 1'b0);
    set_vec(11, "r_sub",    2'b10, 4'b0010, 32'h00000003, 32'h00000005, 4'b0110, 32'hFFFFFFFE, 1'b1, 1'b0);
    set_vec(12, "r_unk",    2'b10, 4'b1111, 32'h80000000, 32'h80000000, 4'b0010, 32'h00000000, 1'b0, 1'b1);
    set_vec(13, "slt_neg",  2'b10, 4'b1010, 32'hFFFFFFFF, 32'h00000001, 4'b0111, 32'h00000001, 1'b0, 1'b0);
    set_vec(14, "add_fnig", 2'b00, 4'b0100, 32'h00000001, 32'h00000001, 4'b0010, 32'h00000002, 1'b0, 1'b0);

    avecs[0] = '{32'h00000010, 32'hFFFFFFF8, 32'h00000014, 32'h0000000C};
    avecs[1] = '{32'hFFFFFFFC, 32'h00000000, 32'h00000000, 32'h00000000};
    avecs[2] = '{32'hFFFFFFFC, 32'h00000008, 32'h00000000, 32'h00000008};
    avecs[3] = '{32'h00000100, 32'h00000040, 32'h00000104, 32'h00000144};

    rst    = 1'b1;
    aluop  = 2'b00;
    funct  = 4'b0000;
    a      = 32'h7FFFFFFF;
    b      = 32'h00000001;
    pc     = 32'd0;
    br_off = 32'd0;

    // Flags held at zero through reset edges even though the ALU output would set N and V.
    #1;
    check_flags("reset_state", 3'b000);
    @(posedge clk);
    #1;
    check_flags("reset_hold", 3'b000);
    check("reset_comb_result", result, 32'h80000000);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) apply_vec(vecs[i]);

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pc     = avecs[i].pc;
      br_off = avecs[i].br_off;
      #1;
      check($sformatf("pc_plus4[%0d]", i), pc_plus4, avecs[i].exp_pc4);
      check($sformatf("br_target[%0d]", i), br_target, avecs[i].exp_bt);
    end

    // Mid-cycle async reset after flags are set: clear without an edge, reload on the first edge after release.
    apply_vec(vecs[0]);
    #2;
    rst = 1'b1;
    #1;
    check_flags("async_clear", 3'b000);
    check("rst_comb_result", result, 32'h80000000);
    @(posedge clk);
    #1;
    check_flags("rst_held_edge", 3'b000);
    @(negedge clk);
    rst = 1'b0;
    flag_q.push_back('{"rst_reload", 3'b110});
    @(posedge clk);
    #1;
    pop_flags();

    // Flags follow the previous cycle with no enable: sub_zero then nori back to back.
    apply_vec(vecs[1]);
    apply_vec(vecs[9]);

    total++;
    if (flag_q.size() != 0) begin
      bad++;
      $display("FAIL flag_queue_drain: got %0d entries expected 0", flag_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage arithmetic block of the single-cycle MIPS-lite datapath.
- Contains three parts:
  - ALU control decoder: aluop plus funct bits produce a 4-bit operation code.
  - 32-bit combinational ALU with a clocked N/V/Z status register.
  - Two 32-bit adders: PC+4 and branch target.
- Status flags feed the brv, baln and blezal branch logic in the next cycle.

Parameters:
- WIDTH, 32, datapath width of operands, result and adders.

Ports:
- clk  in  1  system clock; status register samples on rising edge.
- rst  in  1  asynchronous, active-high reset.
- aluop  in  2  {aluop1, aluop0} from main control.
- funct  in  4  instruction bits [3:0].
- a  in  WIDTH  ALU operand A (register rs).
- b  in  WIDTH  ALU operand B (rt, sign-extended immediate, or zero-extended immediate).
- pc  in  WIDTH  current program counter.
- br_off  in  WIDTH  sign-extended immediate, already shifted left by 2.
- alu_ctl  out  4  decoded operation code (gout).
- result  out  WIDTH  ALU result.
- zero  out  1  combinational; 1 when result == 0.
- status_n  out  1  registered negative flag.
- status_v  out  1  registered overflow flag.
- status_z  out  1  registered zero flag.
- pc_plus4  out  WIDTH  pc + 4.
- br_target  out  WIDTH  pc_plus4 + br_off.

Behaviour:
- ALU control decode (combinational):
  - aluop 00: ADD.
  - aluop 01: SUB.
  - aluop 11: NOR (nori).
  - aluop 10: decode funct:
    - 0000 ADD
    - 0010 SUB
    - 0100 AND
    - 0101 OR
    - 0110 XOR
    - 0111 NOR
    - 1010 SLT
    - any other funct: ADD
- Operation codes: AND 0000, OR 0001, ADD 0010, XOR 0011, SUB 0110, SLT 0111, NOR 1100.
- ALU operations (combinational, no latency):
  - ADD: a + b, modulo 2^32.
  - SUB: a - b, modulo 2^32.
  - AND, OR, XOR: bitwise.
  - NOR: ~(a | b).
  - SLT: result = 1 if signed(a) < signed(b), else 0. Must be a true signed compare, correct even when a - b overflows.
  - Unlisted op code: result = 0.
- Overflow (combinational, internal):
  - ADD: a[31] == b[31] and result[31] != a[31].
  - SUB: a[31] != b[31] and result[31] != a[31].
  - All other ops: 0.
- Status register:
  - On every rising edge of clk: status_n <= result[31], status_v <= overflow, status_z <= zero.
  - No enable; flags always reflect the instruction of the previous cycle.
- Reset:
  - rst high clears status_n, status_v and status_z to 0 immediately, independent of clk.
  - Flags stay 0 while rst is asserted.
  - The first rising edge after rst deassertion loads normally.
  - rst has no effect on the combinational outputs.
- Adders: pure combinational, wrap-around, no carry output. pc = FFFFFFFC gives pc_plus4 = 00000000.
- Simultaneous edge and input change: flags sample the values settled before the edge.

Decomposition:
- Shared package alu_pkg: 4-bit operation code localparams (ALU_AND, ALU_OR, ALU_ADD, ALU_XOR, ALU_SUB, ALU_SLT, ALU_NOR) and aluop encodings.
- One natural sub-module, add32 (WIDTH-bit combinational adder), instantiated twice for pc_plus4 and br_target.
- Control decode, ALU core and flag register live in the top.

Test Plan:
- Reset: assert rst mid-cycle after flags are set → status_n, status_v, status_z = 0 immediately with no clock edge; they reload on the first edge after release.
- ADD overflow: aluop=00, a=7FFFFFFF, b=00000001 → result=80000000, zero=0. After the edge: N=1, V=1, Z=0.
- SUB to zero: aluop=01, a=b=00000005 → result=0, zero=1. After the edge: Z=1, N=0, V=0. SUB overflow: a=80000000, b=00000001 → result=7FFFFFFF, V=1.
- R-type decode: aluop=10 with funct 0100, 0101, 0110, 0111, 1010 and a=F0F0F0F0, b=0FF00FF0:
  - alu_ctl = 0000, 0001, 0011, 1100, 0111 respectively.
  - results 00F000F0, FFF0FFF0, FF00FF00, 000F000F, 00000001.
  - SLT with a=7FFFFFFF, b=80000000 → 0.
- NORI: aluop=11, a=00000000, b=0000FFFF → result=FFFF0000, alu_ctl=1100, N=1 after the edge.
- Adders:
  - pc=00000010, br_off=FFFFFFF8 → pc_plus4=00000014, br_target=0000000C.
  - pc=FFFFFFFC → pc_plus4=00000000.
